// File: rtl/frog_game_sequencer_if.sv
// frog_game_sequencer_if: game-flow inputs from switches/collision/video and status outputs to frog, cars and display
interface frog_game_sequencer_if;
  logic       i_Start;
  logic       i_Has_Collided;
  logic       i_Level_Up;
  logic       i_Frame_Tick;
  logic       o_Game_Active;
  logic       o_Respawn;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Flash;
  logic       o_Game_Over;
  logic [2:0] o_State;
  modport master (
    output i_Start, i_Has_Collided, i_Level_Up, i_Frame_Tick,
    input  o_Game_Active, o_Respawn, o_Lives, o_Level, o_Flash, o_Game_Over, o_State
  );
  modport slave (
    input  i_Start, i_Has_Collided, i_Level_Up, i_Frame_Tick,
    output o_Game_Active, o_Respawn, o_Lives, o_Level, o_Flash, o_Game_Over, o_State
  );
endinterface

// File: rtl/frog_game_sequencer.sv
// frog_game_sequencer: Frogger play flow (idle/running/dying/level-clear/game-over), lives, level and respawn
module frog_game_sequencer #(
  parameter int c_LIVES_INI    = 3,
  parameter int c_DEATH_FRAMES = 60,
  parameter int c_CLEAR_FRAMES = 30,
  parameter int c_MAX_LEVEL    = 15,
  parameter int c_FLASH_BIT    = 3,
  parameter int c_GRACE_CYCLES = 2
) (
  input logic                  i_Clk,
  input logic                  i_Reset,
  frog_game_sequencer_if.slave bus
);
  localparam int GW = $clog2(c_GRACE_CYCLES + 2);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RUNNING     = 3'd1,
    DYING       = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4
  } state_e;
  state_e        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [3:0]    level_q, level_d;
  logic [7:0]    frame_q, frame_d;
  logic [GW-1:0] grace_q, grace_d;
  logic          start_q, respawn_q, active_q, flash_q, over_q;
  logic          start_rise, entering_run;
  assign start_rise   = bus.i_Start & ~start_q;
  assign entering_run = (state_d == RUNNING) && (state_q != RUNNING);
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    frame_d = frame_q;
    grace_d = grace_q;
    case (state_q)
      IDLE: state_d = start_rise ? RUNNING : IDLE;
      RUNNING: begin
        grace_d = grace_q != '0 ? grace_q - GW'(1) : grace_q;
        if (grace_q == '0 && bus.i_Has_Collided) begin
          state_d = DYING;
          lives_d = lives_q - 2'd1;
        end else if (bus.i_Level_Up) begin
          state_d = LEVEL_CLEAR;
          level_d = level_q == 4'(c_MAX_LEVEL) ? level_q : level_q + 4'd1;
        end
      end
      DYING: if (bus.i_Frame_Tick) begin
        frame_d = frame_q + 8'd1;
        if (frame_q == 8'(c_DEATH_FRAMES - 1)) state_d = lives_q == 2'd0 ? GAME_OVER : RUNNING;
      end
      LEVEL_CLEAR: if (bus.i_Frame_Tick) begin
        frame_d = frame_q + 8'd1;
        if (frame_q == 8'(c_CLEAR_FRAMES - 1)) state_d = RUNNING;
      end
      GAME_OVER: if (start_rise) begin
        state_d = RUNNING;
        lives_d = 2'(c_LIVES_INI);
        level_d = '0;
      end
      default: begin
        state_d = IDLE;
        frame_d = '0;
        grace_d = '0;
      end
    endcase
    // every state entry restarts the frame count; RUNNING entry also arms the collision grace window
    if (state_d != state_q) frame_d = '0;
    if (entering_run) grace_d = GW'(c_GRACE_CYCLES);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      lives_q   <= 2'(c_LIVES_INI);
      level_q   <= '0;
      frame_q   <= '0;
      grace_q   <= '0;
      start_q   <= 1'b0;
      respawn_q <= 1'b0;
      active_q  <= 1'b0;
      flash_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      frame_q   <= frame_d;
      grace_q   <= grace_d;
      start_q   <= bus.i_Start;
      respawn_q <= entering_run;
      active_q  <= state_d == RUNNING;
      flash_q   <= (state_d == DYING) && frame_d[c_FLASH_BIT];
      over_q    <= state_d == GAME_OVER;
    end
  end
  assign bus.o_State       = state_q;
  assign bus.o_Lives       = lives_q;
  assign bus.o_Level       = level_q;
  assign bus.o_Respawn     = respawn_q;
  assign bus.o_Game_Active = active_q;
  assign bus.o_Flash       = flash_q;
  assign bus.o_Game_Over   = over_q;
endmodule

// File: tb/tb_frog_game_sequencer.sv
// tb_frog_game_sequencer: directed scenarios plus random play checked against a game-rule reference model
module tb_frog_game_sequencer;
  localparam int LIVES = 3, DEATH = 60, CLEAR = 30, MAXL = 15, GRACE = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  frog_game_sequencer_if bus();
  frog_game_sequencer dut (.i_Clk(clk), .i_Reset(rst), .bus(bus));
  int vecs = 0, errs = 0;
  int m_st, m_lives, m_level, m_ticks, m_age;
  bit m_prev, m_resp, m_flash;
  function automatic void model(bit r, bit s, bit c, bit l, bit t);
    int nx;
    bit rise;
    if (r) begin
      m_st = 0; m_lives = LIVES; m_level = 0; m_ticks = 0; m_age = 0;
      m_prev = 0; m_resp = 0; m_flash = 0;
      return;
    end
    rise = s && !m_prev;
    m_prev = s;
    nx = m_st;
    if (m_st == 0 && rise) nx = 1;
    else if (m_st == 1) begin
      if (m_age >= GRACE && c) begin nx = 2; m_lives--; end
      else if (l) begin nx = 3; m_level = m_level < MAXL ? m_level + 1 : MAXL; end
    end else if ((m_st == 2 || m_st == 3) && t) begin
      m_ticks++;
      if (m_st == 2 && m_ticks == DEATH) nx = m_lives == 0 ? 4 : 1;
      if (m_st == 3 && m_ticks == CLEAR) nx = 1;
    end else if (m_st == 4 && rise) begin
      nx = 1; m_lives = LIVES; m_level = 0;
    end
    m_resp = nx == 1 && m_st != 1;
    if (nx != m_st) begin m_ticks = 0; m_age = 0; end
    else if (m_st == 1) m_age++;
    m_flash = nx == 2 && ((m_ticks / 8) % 2) == 1;
    m_st = nx;
  endfunction
  function automatic logic [12:0] dut_vec();
    return {bus.o_State, bus.o_Game_Active, bus.o_Respawn, bus.o_Lives, bus.o_Level, bus.o_Flash, bus.o_Game_Over};
  endfunction
  function automatic logic [12:0] model_vec();
    return {3'(m_st), m_st == 1, m_resp, 2'(m_lives), 4'(m_level), m_flash, m_st == 4};
  endfunction
  task automatic step(input bit r, input bit s, input bit c, input bit l, input bit t);
    rst = r; bus.i_Start = s; bus.i_Has_Collided = c; bus.i_Level_Up = l; bus.i_Frame_Tick = t;
    @(posedge clk);
    model(r, s, c, l, t);
    #1;
  endtask
  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    vecs++;
    if (dut_vec() !== 13'b000_0_0_11_0000_0_0) begin errs++; $display("FAIL reset: got %h want %h", dut_vec(), 13'b000_0_0_11_0000_0_0); end
  endtask
  task automatic test_start_hold();
    int pulses = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 0);
      pulses += bus.o_Respawn;
      vecs++;
      if (dut_vec() !== model_vec()) begin errs++; $display("FAIL start_hold cyc%0d: got %h want %h", i, dut_vec(), model_vec()); end
    end
    vecs++;
    if (pulses !== 1 || bus.o_State !== 3'd1 || bus.o_Lives !== 2'd3 || bus.o_Level !== 4'd0) begin
      errs++; $display("FAIL start_once: pulses=%0d state=%0d lives=%0d level=%0d want 1/1/3/0", pulses, bus.o_State, bus.o_Lives, bus.o_Level);
    end
  endtask
  task automatic test_grace();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 0, 0);
      vecs++;
      if (bus.o_State !== 3'd1 || dut_vec() !== model_vec()) begin errs++; $display("FAIL grace cyc%0d: got %h want %h", i, dut_vec(), model_vec()); end
    end
    step(0, 0, 1, 0, 0);
    vecs++;
    if (bus.o_State !== 3'd2 || bus.o_Lives !== 2'd2) begin errs++; $display("FAIL grace_hit: state=%0d lives=%0d want 2/2", bus.o_State, bus.o_Lives); end
  endtask
  task automatic test_dying();
    int toggles = 0;
    logic pf = bus.o_Flash;
    for (int i = 0; i < DEATH - 1; i++) begin
      step(0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1);
      step(0, 0, 0, 0, 0);
      toggles += int'(bus.o_Flash != pf);
      pf = bus.o_Flash;
      vecs++;
      if (dut_vec() !== model_vec()) begin errs++; $display("FAIL dying tick%0d: got %h want %h", i + 1, dut_vec(), model_vec()); end
    end
    vecs++;
    if (bus.o_State !== 3'd2 || toggles !== 7) begin errs++; $display("FAIL dying_hold: state=%0d toggles=%0d want 2/7", bus.o_State, toggles); end
    step(0, 0, 0, 0, 1);
    vecs++;
    if (bus.o_State !== 3'd1 || bus.o_Respawn !== 1'b1 || bus.o_Flash !== 1'b0) begin
      errs++; $display("FAIL dying_end: state=%0d respawn=%b flash=%b want 1/1/0", bus.o_State, bus.o_Respawn, bus.o_Flash);
    end
  endtask
  task automatic test_game_over();
    for (int d = 0; d < 2; d++) begin
      repeat (GRACE) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < DEATH; i++) step(0, 0, 0, 0, 1);
      vecs++;
      if (dut_vec() !== model_vec()) begin errs++; $display("FAIL death%0d: got %h want %h", d, dut_vec(), model_vec()); end
    end
    vecs++;
    if (bus.o_State !== 3'd4 || bus.o_Game_Over !== 1'b1 || bus.o_Lives !== 2'd0 || bus.o_Game_Active !== 1'b0) begin
      errs++; $display("FAIL game_over: state=%0d over=%b lives=%0d want 4/1/0", bus.o_State, bus.o_Game_Over, bus.o_Lives);
    end
    step(0, 1, 0, 0, 0);
    vecs++;
    if (bus.o_State !== 3'd1 || bus.o_Lives !== 2'd3 || bus.o_Level !== 4'd0 || bus.o_Respawn !== 1'b1) begin
      errs++; $display("FAIL restart: state=%0d lives=%0d level=%0d respawn=%b want 1/3/0/1", bus.o_State, bus.o_Lives, bus.o_Level, bus.o_Respawn);
    end
  endtask
  task automatic test_priority();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < CLEAR; i++) step(0, 0, 0, 0, 1);
    repeat (GRACE) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    vecs++;
    if (bus.o_State !== 3'd2 || bus.o_Level !== 4'd1 || bus.o_Lives !== 2'd2) begin
      errs++; $display("FAIL priority: state=%0d level=%0d lives=%0d want 2/1/2", bus.o_State, bus.o_Level, bus.o_Lives);
    end
    for (int i = 0; i < DEATH; i++) step(0, 0, 0, 0, 1);
  endtask
  task automatic test_level_sat();
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < CLEAR; i++) step(0, 0, 0, 0, 1);
      vecs++;
      if (dut_vec() !== model_vec()) begin errs++; $display("FAIL level%0d: got %h want %h", k, dut_vec(), model_vec()); end
    end
    vecs++;
    if (bus.o_Level !== 4'd15 || bus.o_State !== 3'd1) begin errs++; $display("FAIL level_sat: level=%0d state=%0d want 15/1", bus.o_Level, bus.o_State); end
  endtask
  task automatic test_reset_mid_dying();
    repeat (GRACE) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    vecs++;
    if (dut_vec() !== 13'b000_0_0_11_0000_0_0) begin errs++; $display("FAIL mid_reset: got %h want %h", dut_vec(), 13'b000_0_0_11_0000_0_0); end
    for (int i = 0; i < 70; i++) step(0, 0, 1, 1, 1);
    vecs++;
    if (bus.o_State !== 3'd0 || bus.o_Respawn !== 1'b0) begin errs++; $display("FAIL idle_ticks: state=%0d respawn=%b want 0/0", bus.o_State, bus.o_Respawn); end
  endtask
  task automatic test_random();
    bit s = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(19) == 0) s = !s;
      step($urandom_range(599) == 0, s, $urandom_range(7) == 0, $urandom_range(29) == 0, $urandom_range(2) == 0);
      vecs++;
      if (dut_vec() !== model_vec()) begin errs++; $display("FAIL random cyc%0d: got %h want %h", i, dut_vec(), model_vec()); end
    end
  endtask
  initial begin
    test_reset();
    test_start_hold();
    test_grace();
    test_dying();
    test_game_over();
    test_priority();
    test_level_sat();
    test_reset_mid_dying();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
